btn_debounce_multi: RTL and testbench
=====================================

# btn_debounce_multi

Multi-channel button conditioner: a parametrised successor to the single-button debouncer. Each channel synchronises a raw button, debounces it in both directions, and emits a debounced level plus one-cycle press, release and auto-repeat strobes. It sits between the board push-buttons and the control FSMs, for example the LIFO push/pop and mode logic, and replaces per-button debounce instances.

## Interface
- `CHANNELS`, 5: number of independent buttons.
- `CNT_W`, 19: width of the debounce counter. Must satisfy 2^CNT_W > STABLE_CYCLES.
- `STABLE_CYCLES`, 500000: consecutive cycles at the new value required before the level flips. 10 ms at 50 MHz. Legal values are ≥2.
- `RPT_W`, 26: width of the repeat counter. Must satisfy 2^RPT_W > max(REPEAT_DELAY, REPEAT_RATE).
- `REPEAT_DELAY`, 25000000: held cycles after the press strobe before the first repeat strobe. Legal values are ≥1.
- `REPEAT_RATE`, 5000000: cycles between subsequent repeat strobes. Legal values are ≥1.
- `REPEAT_EN`, 1: when 0, `o_repeat` is tied 0 and the repeat logic is removed.

Ports:
- `i_clk`, input, 1: the single clock. All logic runs on its rising edge.
- `i_rst`, input, 1: synchronous, active-high reset.
- `i_btn`, input, CHANNELS: raw asynchronous buttons, active-high.
- `o_level`, output, CHANNELS: debounced button state.
- `o_press`, output, CHANNELS: one-cycle strobe when the level goes 0→1.
- `o_release`, output, CHANNELS: one-cycle strobe when the level goes 1→0.
- `o_repeat`, output, CHANNELS: one-cycle auto-repeat strobe while the button is held.
- `o_any_press`, output, 1: registered OR of the `i_btn` press events. It is high in the same cycle as any `o_press` bit.

## Operation
- Channels are fully independent. There is no shared state between channels.
- **Synchroniser:** a 2-flop synchroniser per channel. Its output `s` is the only internal use of `i_btn`.
- **Debounce counter `cnt`:**
  - When `s == o_level`: `cnt` ← 0. Any bounce therefore restarts the window.
  - When `s != o_level` and `cnt == STABLE_CYCLES-1`:
    - `o_level` ← `s` and `cnt` ← 0.
    - `o_press` or `o_release` fires in that same update.
  - Otherwise `cnt` increments.
  - `cnt` never exceeds STABLE_CYCLES-1 and never wraps.
- **Repeat FSM per channel.** It has three states: `IDLE`, `DELAY`, `RATE`.
  - `IDLE` → `DELAY` on the press update, with `rcnt` ← 0.
  - In `DELAY`, `rcnt` increments. At `rcnt == REPEAT_DELAY-1`:
    - `o_repeat` pulses, `rcnt` ← 0, and the FSM moves to `RATE`.
  - In `RATE`, `rcnt` increments. At `rcnt == REPEAT_RATE-1`:
    - `o_repeat` pulses, `rcnt` ← 0, and the FSM stays in `RATE`.
  - The release update in any state goes to `IDLE` and suppresses any repeat due in that cycle.
  - Release has priority over repeat.
- **Reset** (`i_rst` = 1 at an edge):
  - Clears synchroniser flops, `cnt`, `rcnt`, the FSM (to `IDLE`) and all outputs.
  - A button held through reset reads as a fresh press: the full STABLE_CYCLES window follows, then `o_press`.
  - Reset mid-window discards partial counts.
  - No strobe is emitted in the cycle following reset.

## Timing
- **Reset values:** `o_level`, `o_press`, `o_release`, `o_repeat` and `o_any_press` are all 0.
- **Output registers:** all outputs are registered. Strobes are exactly one cycle wide.
- **Press latency:** raw input first sampled high at edge k, and stable thereafter:
  - `s` is high after edge k+1.
  - `o_level` and `o_press` are high after edge k+1+STABLE_CYCLES.
  - `o_press` is low again after the following edge.
- **Release latency:** symmetric with press latency.
- **First repeat:** high after edge P+REPEAT_DELAY, where P is the edge that raised `o_press`.
- **Later repeats:** every REPEAT_RATE cycles after the first.
- **Throughput:** maximum toggle rate is one level change per STABLE_CYCLES cycles.
- **Press and release never coincide** on one channel. Different channels may strobe in the same cycle.

## Structure
- **Shared package:**
  - Repeat FSM state encoding (2-bit: `IDLE`=0, `DELAY`=1, `RATE`=2).
  - A clog2 helper function for bench width checks.
  - Default timing constants (`STABLE_CYCLES`, `REPEAT_DELAY`, `REPEAT_RATE` for 50 MHz).
- **Sub-module `btn_debounce_chan`:** one channel, containing the synchroniser, debounce counter and repeat FSM. The top level instantiates it CHANNELS times in a generate loop and forms `o_any_press`.

## Test plan
Bench parameters: STABLE_CYCLES=4, REPEAT_DELAY=10, REPEAT_RATE=3, CHANNELS=2.
1. **Clean press.** Ch0 high at edge 0 and held. Expect `o_press[0]` high after edge 5 only, `o_level[0]`=1 from edge 5, and `o_any_press`=1 at edge 5.
2. **Bounce.** Ch0 pattern 1,1,1,0,1,1,1,1 and then held. Expect no strobe before the window restarts, and `o_press` 4 cycles after the last 0 clears through the synchroniser.
3. **Auto-repeat.** Hold ch0 30 cycles after the press at P. Expect `o_repeat` at P+10, P+13, P+16 and so on. Then release and expect no `o_repeat` after the `o_release` strobe.
4. **Release on repeat cycle.** Time the release update to coincide with a scheduled repeat. Expect `o_release`=1 and `o_repeat`=0 in that cycle.
5. **Reset mid-operation.** Assert `i_rst` for 1 cycle while ch1 is held at `cnt`=2 and in `RATE`. Expect all outputs 0, then a fresh `o_press[1]` 5 cycles after reset release (4 + synchroniser).
6. **Independence.** Press ch0 and ch1 with 1-cycle skew. Expect `o_press[0]` and `o_press[1]` one cycle apart, and `o_any_press` high in both cycles.

Source files
------------

// File: rtl/btn_debounce_pkg.sv
// Shared definitions for the multi-channel button conditioner: repeat FSM
// encoding, default 50 MHz timing constants and a width helper.
package btn_debounce_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DELAY = 2'd1,
        RATE  = 2'd2
    } rpt_state_e;

    localparam int DEF_STABLE_CYCLES = 500000;
    localparam int DEF_REPEAT_DELAY  = 25000000;
    localparam int DEF_REPEAT_RATE   = 5000000;

    // Ceiling log2; clog2_f(N+1) is the width needed to hold the value N.
    function automatic int clog2_f(input int v);
        int r;
        int x;
        r = 0;
        x = v - 1;
        while (x > 0) begin
            r = r + 1;
            x = x >> 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/btn_debounce_chan.sv
// One button channel: 2-flop synchroniser, symmetric debounce counter and
// the auto-repeat FSM that runs while the debounced level is held high.
module btn_debounce_chan
    import btn_debounce_pkg::*;
#(
    parameter int CNT_W         = 19,
    parameter int STABLE_CYCLES = DEF_STABLE_CYCLES,
    parameter int RPT_W         = 26,
    parameter int REPEAT_DELAY  = DEF_REPEAT_DELAY,
    parameter int REPEAT_RATE   = DEF_REPEAT_RATE,
    parameter int REPEAT_EN     = 1
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_btn,
    output logic o_level,
    output logic o_press,
    output logic o_release,
    output logic o_repeat,
    output logic o_press_evt
);

    logic [1:0]       sync_q;
    logic             s;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             level_q, level_d;
    logic             press_q, press_d;
    logic             release_q, release_d;
    logic             flip;

    assign s = sync_q[1];

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            sync_q <= 2'b00;
        end else begin
            sync_q <= {sync_q[0], i_btn};
        end
    end

    // Any sample equal to the current level restarts the stability window.
    always_comb begin
        cnt_d   = cnt_q;
        level_d = level_q;
        flip    = 1'b0;
        if (s == level_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_W'(STABLE_CYCLES - 1)) begin
            flip    = 1'b1;
            level_d = s;
            cnt_d   = '0;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    assign press_d   = flip & s;
    assign release_d = flip & ~s;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            cnt_q     <= '0;
            level_q   <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            level_q   <= level_d;
            press_q   <= press_d;
            release_q <= release_d;
        end
    end

    assign o_level     = level_q;
    assign o_press     = press_q;
    assign o_release   = release_q;
    assign o_press_evt = press_d;

    if (REPEAT_EN != 0) begin : g_rpt
        rpt_state_e       state_q, state_d;
        logic [RPT_W-1:0] rcnt_q, rcnt_d;
        logic             rpt_q, rpt_d;

        // Release is checked first so it wins over a repeat due in the same cycle.
        always_comb begin
            state_d = state_q;
            rcnt_d  = rcnt_q;
            rpt_d   = 1'b0;
            if (release_d) begin
                state_d = IDLE;
                rcnt_d  = '0;
            end else if (press_d) begin
                state_d = DELAY;
                rcnt_d  = '0;
            end else begin
                case (state_q)
                    DELAY: begin
                        if (rcnt_q == RPT_W'(REPEAT_DELAY - 1)) begin
                            rpt_d   = 1'b1;
                            rcnt_d  = '0;
                            state_d = RATE;
                        end else begin
                            rcnt_d = rcnt_q + RPT_W'(1);
                        end
                    end
                    RATE: begin
                        if (rcnt_q == RPT_W'(REPEAT_RATE - 1)) begin
                            rpt_d  = 1'b1;
                            rcnt_d = '0;
                        end else begin
                            rcnt_d = rcnt_q + RPT_W'(1);
                        end
                    end
                    default: begin
                        state_d = IDLE;
                        rcnt_d  = '0;
                    end
                endcase
            end
        end

        always_ff @(posedge i_clk) begin
            if (i_rst) begin
                state_q <= IDLE;
                rcnt_q  <= '0;
                rpt_q   <= 1'b0;
            end else begin
                state_q <= state_d;
                rcnt_q  <= rcnt_d;
                rpt_q   <= rpt_d;
            end
        end

        assign o_repeat = rpt_q;
    end else begin : g_norpt
        assign o_repeat = 1'b0;
    end

endmodule

// File: rtl/btn_debounce_multi.sv
// Multi-channel button conditioner: CHANNELS independent debounce channels
// plus a registered "any press" strobe aligned with the per-channel press bits.
module btn_debounce_multi
    import btn_debounce_pkg::*;
#(
    parameter int CHANNELS      = 5,
    parameter int CNT_W         = 19,
    parameter int STABLE_CYCLES = DEF_STABLE_CYCLES,
    parameter int RPT_W         = 26,
    parameter int REPEAT_DELAY  = DEF_REPEAT_DELAY,
    parameter int REPEAT_RATE   = DEF_REPEAT_RATE,
    parameter int REPEAT_EN     = 1
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic [CHANNELS-1:0] i_btn,
    output logic [CHANNELS-1:0] o_level,
    output logic [CHANNELS-1:0] o_press,
    output logic [CHANNELS-1:0] o_release,
    output logic [CHANNELS-1:0] o_repeat,
    output logic                o_any_press
);

    logic [CHANNELS-1:0] press_evt;
    logic                any_q, any_d;

    for (genvar g = 0; g < CHANNELS; g++) begin : g_chan
        btn_debounce_chan #(
            .CNT_W        (CNT_W),
            .STABLE_CYCLES(STABLE_CYCLES),
            .RPT_W        (RPT_W),
            .REPEAT_DELAY (REPEAT_DELAY),
            .REPEAT_RATE  (REPEAT_RATE),
            .REPEAT_EN    (REPEAT_EN)
        ) u_chan (
            .i_clk      (i_clk),
            .i_rst      (i_rst),
            .i_btn      (i_btn[g]),
            .o_level    (o_level[g]),
            .o_press    (o_press[g]),
            .o_release  (o_release[g]),
            .o_repeat   (o_repeat[g]),
            .o_press_evt(press_evt[g])
        );
    end

    // Built from the next-state press events so it lands with o_press.
    assign any_d = |press_evt;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            any_q <= 1'b0;
        end else begin
            any_q <= any_d;
        end
    end

    assign o_any_press = any_q;

endmodule

// File: tb/tb_btn_debounce_multi.sv
// Bench for btn_debounce_multi: directed scenarios plus random button activity
// compared each cycle against a window-based reference model.
module tb_btn_debounce_multi;
    import btn_debounce_pkg::*;

    localparam int CH = 2;
    localparam int S  = 4;
    localparam int D  = 10;
    localparam int R  = 3;
    localparam int CW = clog2_f(S + 1);
    localparam int RW = clog2_f(((D > R) ? D : R) + 1);

    logic          clk = 1'b0;
    logic          rst;
    logic [CH-1:0] btn;
    logic [CH-1:0] lvl, prs, rls, rpt;
    logic          anyp;

    always #5 clk = ~clk;

    btn_debounce_multi #(
        .CHANNELS     (CH),
        .CNT_W        (CW),
        .STABLE_CYCLES(S),
        .RPT_W        (RW),
        .REPEAT_DELAY (D),
        .REPEAT_RATE  (R),
        .REPEAT_EN    (1)
    ) dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_btn      (btn),
        .o_level    (lvl),
        .o_press    (prs),
        .o_release  (rls),
        .o_repeat   (rpt),
        .o_any_press(anyp)
    );

    int total = 0;
    int bad   = 0;
    int e     = 0;
    int last_rst = 0;

    logic [CH-1:0] raw_h [0:4095];
    logic          rst_h [0:4095];
    logic [CH-1:0] m_lvl;
    int            pe [CH];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s @edge%0d got=%0h exp=%0h", tag, e, got, exp);
        end
    endtask

    // Synchronised value the design sees at edge ed: the raw sample from two
    // edges earlier, or 0 if either synchroniser flop was reset in between.
    function automatic logic s_at(input int ch, input int ed);
        if (ed < 3) return 1'b0;
        if (rst_h[ed-1] || rst_h[ed-2]) return 1'b0;
        return raw_h[ed-2][ch];
    endfunction

    task automatic step();
        logic [CH-1:0] xp, xr, xrp;
        logic          flip;
        int            el;
        @(posedge clk);
        e++;
        rst_h[e] = rst;
        raw_h[e] = btn;
        #1;
        xp = '0; xr = '0; xrp = '0;
        if (rst) begin
            m_lvl    = '0;
            last_rst = e;
        end else begin
            for (int ch = 0; ch < CH; ch++) begin
                // Level flips when the last S synchronised samples since reset all differ from it.
                flip = 1'b1;
                for (int j = 0; j < S; j++) begin
                    if ((e - j) <= last_rst || s_at(ch, e - j) == m_lvl[ch]) flip = 1'b0;
                end
                if (flip) begin
                    if (!m_lvl[ch]) begin
                        xp[ch] = 1'b1;
                        pe[ch] = e;
                    end else begin
                        xr[ch] = 1'b1;
                    end
                    m_lvl[ch] = ~m_lvl[ch];
                end else if (m_lvl[ch]) begin
                    el = e - pe[ch];
                    if (el >= D && ((el - D) % R) == 0) xrp[ch] = 1'b1;
                end
            end
        end
        check("level",   32'(lvl),  32'(m_lvl));
        check("press",   32'(prs),  32'(xp));
        check("release", 32'(rls),  32'(xr));
        check("repeat",  32'(rpt),  32'(xrp));
        check("any",     32'(anyp), 32'(|xp));
    endtask

    initial begin
        int k;
        int hold [CH];
        int pat [8] = '{1, 1, 1, 0, 1, 1, 1, 1};
        m_lvl = '0;
        for (int c = 0; c < CH; c++) begin
            pe[c]   = -1000;
            hold[c] = 0;
        end
        rst = 1'b1;
        btn = '0;
        for (int i = 0; i < 3; i++) step();
        rst = 1'b0;
        step();

        // Clean press, held into auto-repeat, then release.
        btn[0] = 1'b1;
        k = e + 1;
        for (int i = 0; i < 8; i++) begin
            step();
            if (e == k + S + 1) begin
                check("t1_press_edge", 32'(prs[0]), 32'd1);
                check("t1_any_edge", 32'(anyp), 32'd1);
            end
        end
        for (int i = 0; i < 30; i++) begin
            step();
            if (e == pe[0] + D + R) check("t3_second_repeat", 32'(rpt[0]), 32'd1);
        end
        btn[0] = 1'b0;
        for (int i = 0; i < 12; i++) step();

        // Bounce restarts the window.
        foreach (pat[i]) begin
            btn[0] = pat[i][0];
            step();
        end
        for (int i = 0; i < 10; i++) step();

        // Release update lands on a scheduled repeat (P+16).
        for (int i = 0; i < 100 && e != pe[0] + D; i++) step();
        btn[0] = 1'b0;
        for (int i = 0; i < 8; i++) begin
            step();
            if (e == pe[0] + D + 2 * R) begin
                check("t4_release", 32'(rls[0]), 32'd1);
                check("t4_no_repeat", 32'(rpt[0]), 32'd0);
            end
        end

        // Reset while ch1 is in RATE with a partial debounce count.
        btn[1] = 1'b1;
        for (int i = 0; i < 100 && e != pe[1] + D + 4; i++) step();
        btn[1] = 1'b0;
        for (int i = 0; i < 4; i++) step();
        btn[1] = 1'b1;
        rst = 1'b1;
        step();
        k = e;
        rst = 1'b0;
        for (int i = 0; i < 12; i++) begin
            step();
            if (e == k + 1) check("t5_no_strobe", 32'(prs | rls | rpt), 32'd0);
            if (e == k + S + 2) check("t5_fresh_press", 32'(prs[1]), 32'd1);
        end

        // Two channels pressed with one cycle of skew.
        btn = '0;
        for (int i = 0; i < 10; i++) step();
        btn[0] = 1'b1;
        k = e + 1;
        step();
        btn[1] = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            if (e == k + S + 1) check("t6_press_ch0", {30'd0, prs}, 32'h1);
            if (e == k + S + 2) check("t6_press_ch1", {30'd0, prs}, 32'h2);
            if (e == k + S + 1 || e == k + S + 2) check("t6_any", 32'(anyp), 32'd1);
        end

        // Random activity with occasional reset.
        for (int i = 0; i < 900; i++) begin
            for (int c = 0; c < CH; c++) begin
                if (hold[c] == 0) begin
                    btn[c]  = 1'($urandom_range(0, 1));
                    hold[c] = ($urandom_range(0, 3) == 0) ? $urandom_range(10, 30)
                                                          : $urandom_range(0, 6);
                end else begin
                    hold[c]--;
                end
            end
            rst = ($urandom_range(0, 199) == 0);
            step();
        end
        rst = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
